// File: rtl/icache_burst_nway.sv
// rtl/icache_burst_nway.sv - N-way set-associative instruction cache with multi-word fetch and burst refill
// Blocking: one outstanding miss; hits are answered combinationally from IDLE.
module icache_burst_nway #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAY_NUM      = 2,
  parameter int FETCH_NUM    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   cpu_inst_req,
  input  logic [31:0]            cpu_inst_addr,
  output logic                   cpu_inst_addr_ok,
  output logic                   cpu_inst_data_ok,
  output logic [32*FETCH_NUM-1:0] cpu_inst_rdata,
  output logic [FETCH_NUM-1:0]   cpu_inst_rvalid,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [31:0]            rdata,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);
  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int WORDS  = 1 << (OFFSET_WIDTH - 2);
  localparam int WOFF_W = OFFSET_WIDTH - 2;
  localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_REFILL, S_RESP} state_e;
  state_e state_q, state_d;

  logic [WAY_NUM-1:0] valid_q [SETS];
  logic [TAG_W-1:0]   tag_q   [WAY_NUM][SETS];
  logic [31:0]        data_q  [WAY_NUM][SETS][WORDS];
  logic [WAY_W-1:0]   vp_q    [SETS];
  logic [31:0]        lb_q    [WORDS];
  logic [WOFF_W-1:0]  bc_q;

  logic [TAG_W-1:0]       req_tag_q;
  logic [INDEX_WIDTH-1:0] req_idx_q;
  logic [WOFF_W-1:0]      req_off_q;
  logic [WAY_W-1:0]       victim_q;
  logic                   victim_rr_q;
  logic                   flush_pend_q;

  logic [TAG_W-1:0]       a_tag;
  logic [INDEX_WIDTH-1:0] a_idx;
  logic [WOFF_W-1:0]      a_off;
  logic                   unused_addr_bits;

  assign a_tag = cpu_inst_addr[31 -: TAG_W];
  assign a_idx = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign a_off = cpu_inst_addr[2 +: WOFF_W];
  assign unused_addr_bits = ^cpu_inst_addr[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic             flush_eff;
  logic             miss_start;
  logic             line_wr;
  logic [WAY_W-1:0] vp_next;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (valid_q[a_idx][w] && (tag_q[w][a_idx] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[a_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign flush_eff  = (state_q == S_IDLE) && (flush || flush_pend_q);
  assign miss_start = (state_q == S_IDLE) && !flush_eff && cpu_inst_req && !hit;
  assign line_wr    = (state_q == S_REFILL) && rvalid && rlast;
  assign vp_next    = (WAY_NUM == 1) ? '0 : vp_q[req_idx_q] + 1'b1;

  always_comb begin
    state_d          = state_q;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    arvalid          = 1'b0;
    rready           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush_eff && cpu_inst_req) begin
          if (hit) begin
            cpu_inst_addr_ok = 1'b1;
            cpu_inst_data_ok = 1'b1;
          end else begin
            state_d = S_MISS;
          end
        end
      end
      S_MISS: begin
        arvalid = 1'b1;
        if (arready) begin
          cpu_inst_addr_ok = 1'b1;
          state_d          = S_REFILL;
        end
      end
      S_REFILL: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = S_RESP;
      end
      S_RESP: begin
        cpu_inst_data_ok = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [31:0]       line_w [WORDS];
  logic [WOFF_W-1:0] rd_off;

  always_comb begin
    rd_off = (state_q == S_RESP) ? req_off_q : a_off;
    for (int i = 0; i < WORDS; i++) begin
      line_w[i] = (state_q == S_RESP) ? lb_q[i] : data_q[hit_way][a_idx][i];
    end
  end

  // Words past the end of the line are masked off and driven as zero.
  always_comb begin
    cpu_inst_rdata  = '0;
    cpu_inst_rvalid = '0;
    for (int k = 0; k < FETCH_NUM; k++) begin
      if (cpu_inst_data_ok && ((int'(rd_off) + k) < WORDS)) begin
        cpu_inst_rvalid[k]         = 1'b1;
        cpu_inst_rdata[32*k +: 32] = line_w[rd_off + WOFF_W'(k)];
      end
    end
  end

  assign araddr = {req_tag_q, req_idx_q, {OFFSET_WIDTH{1'b0}}};
  assign arlen  = 4'(WORDS - 1);
  assign arsize = 3'b010;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      bc_q         <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_off_q    <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) flush_pend_q <= 1'b0;
      else if (flush)        flush_pend_q <= 1'b1;
      if (miss_start) begin
        req_tag_q   <= a_tag;
        req_idx_q   <= a_idx;
        req_off_q   <= a_off;
        victim_q    <= inv_found ? inv_way : vp_q[a_idx];
        victim_rr_q <= !inv_found;
      end
      if (state_q == S_MISS && arready) bc_q <= '0;
      else if (state_q == S_REFILL && rvalid) bc_q <= bc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_eff) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vp_q[s]    <= '0;
      end
    end else if (line_wr) begin
      valid_q[req_idx_q][victim_q] <= 1'b1;
      if (victim_rr_q) vp_q[req_idx_q] <= vp_next;
    end
  end

  // The rlast beat bypasses the line buffer so the whole line lands in one write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_REFILL && rvalid) lb_q[bc_q] <= rdata;
    if (!rst && line_wr) begin
      tag_q[victim_q][req_idx_q] <= req_tag_q;
      for (int i = 0; i < WORDS; i++) begin
        data_q[victim_q][req_idx_q][i] <= (WOFF_W'(i) == bc_q) ? rdata : lb_q[i];
      end
    end
  end

endmodule

// File: tb/tb_icache_burst_nway.sv
// tb/tb_icache_burst_nway.sv - scoreboard bench for icache_burst_nway
// Directed scenarios followed by random fetches against a line/way reference model.
module tb_icache_burst_nway;
  localparam int IW = 7, OW = 5, WN = 2, FN = 2, W = 8, SETS = 128;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        addr_ok, data_ok;
  logic [63:0] irdata;
  logic [1:0]  irvalid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, rready;
  logic        arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;

  icache_burst_nway #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .WAY_NUM(WN), .FETCH_NUM(FN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cpu_inst_req(req), .cpu_inst_addr(addr),
    .cpu_inst_addr_ok(addr_ok), .cpu_inst_data_ok(data_ok),
    .cpu_inst_rdata(irdata), .cpu_inst_rvalid(irvalid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h0FE0000) return 32'hA0 + {29'd0, a[4:2]};
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  typedef struct {
    bit          hit;
    logic [31:0] araddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
  } exp_t;
  exp_t exp_q[$];

  bit          m_valid [WN][SETS];
  logic [19:0] m_tag   [WN][SETS];
  int          m_vp    [SETS];

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_vp[s] = 0;
      for (int w = 0; w < WN; w++) m_valid[w][s] = 1'b0;
    end
  endfunction

  function automatic exp_t model_access(input logic [31:0] a);
    exp_t e;
    int idx = int'(a[11:5]);
    int off = int'(a[4:2]);
    logic [19:0] t = a[31:12];
    int way = -1;
    e.hit = 1'b0;
    for (int w = 0; w < WN; w++) if (m_valid[w][idx] && m_tag[w][idx] == t) e.hit = 1'b1;
    if (!e.hit) begin
      for (int w = WN - 1; w >= 0; w--) if (!m_valid[w][idx]) way = w;
      if (way < 0) begin
        way = m_vp[idx];
        m_vp[idx] = (m_vp[idx] + 1) % WN;
      end
      m_valid[way][idx] = 1'b1;
      m_tag[way][idx] = t;
    end
    e.araddr = {a[31:5], 5'b0};
    e.rdata = '0;
    e.rvalid = '0;
    for (int k = 0; k < FN; k++) begin
      if (off + k < W) begin
        e.rvalid[k] = 1'b1;
        e.rdata[32*k +: 32] = mem_word(e.araddr + 32'(4 * (off + k)));
      end
    end
    return e;
  endfunction

  // AXI read slave: random AR delay and beat gaps, data from mem_word.
  bit          resp_en = 1'b1, ar_seen = 1'b0;
  logic [31:0] ar_addr = 32'h0;
  int          ar_dly = -1, rsp_d = 0, gap = 0;
  int unsigned rl_cyc = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en && arvalid && !rst) begin
        rsp_d = (ar_dly >= 0) ? ar_dly : $urandom_range(0, 3);
        repeat (rsp_d) begin @(posedge clk); #1; end
        arready = 1'b1;
        ar_addr = araddr;
        @(posedge clk); #1;
        arready = 1'b0;
        ar_seen = 1'b1;
        for (int b = 0; b < W; b++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
          rvalid = 1'b1;
          rlast = (b == W - 1);
          rdata = mem_word(ar_addr + 32'(4 * b));
          @(posedge clk); #1;
          if (b == W - 1) rl_cyc = cyc;
          rvalid = 1'b0;
          rlast = 1'b0;
          rdata = 32'h0;
        end
      end
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && data_ok) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_data_ok: got data_ok=1 expected no response");
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_hit", {63'd0, !ar_seen}, {63'd0, mon_e.hit});
        if (!mon_e.hit) check("sb_araddr", ar_addr, mon_e.araddr);
        check("sb_rdata", irdata, mon_e.rdata);
        check("sb_rvalid", irvalid, mon_e.rvalid);
      end
      ar_seen = 1'b0;
    end
  end

  logic [63:0] got_rdata;
  logic [1:0]  got_rvalid;
  bit          got_hit, got_fired;
  int unsigned got_cyc;

  task automatic fetch(input logic [31:0] a, input bit with_flush, input bit flush_mid);
    exp_t e;
    bit done = 1'b0, fire = 1'b0;
    if (with_flush) model_clear();
    e = model_access(a);
    exp_q.push_back(e);
    got_fired = 1'b0;
    got_hit = 1'b0;
    req = 1'b1;
    addr = a;
    if (with_flush) begin
      flush = 1'b1;
      @(negedge clk);
      check("flush_cycle_data_ok", {63'd0, data_ok}, 64'd0);
      check("flush_cycle_addr_ok", {63'd0, addr_ok}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (data_ok) begin
        done = 1'b1;
        got_hit = (c == 0);
        got_rdata = irdata;
        got_rvalid = irvalid;
        got_cyc = cyc;
      end else if (flush_mid && !got_fired && rvalid && rready) begin
        fire = 1'b1;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (fire) begin
        flush = 1'b1;
        fire = 1'b0;
        got_fired = 1'b1;
      end
    end
    req = 1'b0;
    flush = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL fetch_timeout: no data_ok for addr %h", a);
    end
    check("hit_latency", {63'd0, got_hit}, {63'd0, e.hit});
    if (got_fired) model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra;
  int r, rt, ri, ro;
  bit rr_seen;

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr_ok", {63'd0, addr_ok}, 64'd0);
    check("rst_data_ok", {63'd0, data_ok}, 64'd0);
    check("rst_rdata", irdata, 64'd0);
    check("rst_rvalid", {62'd0, irvalid}, 64'd0);
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_araddr", {32'd0, araddr}, 64'd0);
    @(posedge clk); #1;

    ar_dly = 2;
    fetch(32'h1FC0_0004, 1'b0, 1'b0);
    ar_dly = -1;
    check("cold_hit", {63'd0, got_hit}, 64'd0);
    check("cold_araddr", {32'd0, ar_addr}, 64'h1FC0_0000);
    check("cold_arlen", {60'd0, arlen}, 64'd7);
    check("cold_arsize", {61'd0, arsize}, 64'd2);
    check("cold_rdata", got_rdata, 64'h0000_00A2_0000_00A1);
    check("cold_rvalid", {62'd0, got_rvalid}, 64'd3);
    check("cold_dok_at_rlast_plus1", {32'd0, got_cyc}, {32'd0, rl_cyc});

    fetch(32'h1FC0_001C, 1'b0, 1'b0);
    check("edge_hit", {63'd0, got_hit}, 64'd1);
    check("edge_rdata", got_rdata, 64'h0000_0000_0000_00A7);
    check("edge_rvalid", {62'd0, got_rvalid}, 64'd1);

    fetch(32'h1FC0_0004, 1'b1, 1'b0);
    check("flush_refetch_miss", {63'd0, got_hit}, 64'd0);

    fetch(32'h0000_2048, 1'b0, 1'b1);
    check("midflush_fired", {63'd0, got_fired}, 64'd1);
    fetch(32'h0000_2048, 1'b0, 1'b0);
    check("midflush_refetch_miss", {63'd0, got_hit}, 64'd0);

    fetch(32'h0000_1000, 1'b0, 1'b0);
    fetch(32'h0000_2000, 1'b0, 1'b0);
    fetch(32'h0000_3000, 1'b0, 1'b0);
    check("conf_c_miss", {63'd0, got_hit}, 64'd0);
    fetch(32'h0000_2004, 1'b0, 1'b0);
    check("conf_b_kept", {63'd0, got_hit}, 64'd1);
    fetch(32'h0000_4000, 1'b0, 1'b0);
    check("conf_d_miss", {63'd0, got_hit}, 64'd0);
    fetch(32'h0000_3008, 1'b0, 1'b0);
    check("conf_c_kept", {63'd0, got_hit}, 64'd1);
    fetch(32'h0000_2000, 1'b0, 1'b0);
    check("conf_b_evicted", {63'd0, got_hit}, 64'd0);

    resp_en = 1'b0;
    req = 1'b1;
    addr = 32'h0000_5044;
    for (int c = 0; c < 20 && !arvalid; c++) @(negedge clk);
    check("rstrefill_arvalid", {63'd0, arvalid}, 64'd1);
    @(posedge clk); #1;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1;
      rdata = 32'hDEAD_0000 + 32'(b);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrefill_arvalid_low", {63'd0, arvalid}, 64'd0);
    check("rstrefill_rready_low", {63'd0, rready}, 64'd0);
    rr_seen = 1'b0;
    for (int b = 3; b < W; b++) begin
      @(posedge clk); #1;
      rvalid = 1'b1;
      rlast = (b == W - 1);
      rdata = 32'hDEAD_0000 + 32'(b);
      @(negedge clk);
      if (rready) rr_seen = 1'b1;
    end
    @(posedge clk); #1;
    rvalid = 1'b0;
    rlast = 1'b0;
    rdata = 32'h0;
    check("rstrefill_beats_ignored", {63'd0, rr_seen}, 64'd0);
    model_clear();
    ar_seen = 1'b0;
    resp_en = 1'b1;
    fetch(32'h0000_5044, 1'b0, 1'b0);
    check("rstrefill_refetch_miss", {63'd0, got_hit}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
      end
      rt = $urandom_range(1, 4);
      ri = $urandom_range(0, 3);
      ro = $urandom_range(0, 31);
      ra = (32'(rt) << 12) | (32'(ri) << 5) | 32'(ro);
      fetch(ra, r == 1, r == 2);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_burst_nway.md
# icache_burst_nway

Parametrised N-way set-associative instruction cache with multi-word fetch and AXI-style burst refill, sitting between the fetch stage (sram-like request/response) and the AXI read channel of the memory interface. The line size, set count, associativity and fetch width are all configurable. The block also adds invalid-way-first replacement with a per-set round-robin victim pointer, per-word fetch valid masks at line end, and a whole-cache flush.

## Interface
- INDEX_WIDTH, 7: set index bits; sets = 2^INDEX_WIDTH.
- OFFSET_WIDTH, 5: line offset bits; words/line W = 2^(OFFSET_WIDTH-2), 2..16.
- WAY_NUM, 2: ways, power of two, 1..8.
- FETCH_NUM, 2: words returned per fetch, 1..4, ≤ W.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  single-cycle pulse: invalidate all lines.
- cpu_inst_req  in  1  fetch request; held with a stable address until cpu_inst_data_ok.
- cpu_inst_addr  in  32  fetch address; bits[1:0] ignored.
- cpu_inst_addr_ok  out  1  request accepted.
- cpu_inst_data_ok  out  1  fetch data valid, one-cycle pulse.
- cpu_inst_rdata  out  32*FETCH_NUM  word k at [32k+31:32k] = word at addr+4k.
- cpu_inst_rvalid  out  FETCH_NUM  bit k set iff word k lies in the same line.
- araddr  out  32  line-aligned address {tag,index,OFFSET zeros}.
- arlen  out  4  constant W-1.
- arsize  out  3  constant 3'b010.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read beat data.
- rlast  in  1  last beat.
- rvalid  in  1  beat valid.
- rready  out  1  beat ready.

## Operation
- Arrays: valid[WAY][SET], tag[WAY][SET], data[WAY][SET][W], victim pointer vp[SET] (max(1,log2 WAY_NUM) bits), line buffer lb[W], beat counter bc.
- FSM states: IDLE, MISS, REFILL, RESP.
- IDLE: if flush, clear all valid bits and all vp; no hit/miss is reported that cycle. Else if req and a way hits, assert addr_ok and data_ok the same cycle, with data read combinationally. Else if req misses, latch tag/index/offset and the victim way, then go to MISS.
- Victim: the lowest-index invalid way in the set; if the set has no invalid way, use vp[index], and vp increments modulo WAY_NUM at line write. The pointer is unchanged when an invalid way is used.
- MISS: arvalid=1. On arvalid&arready, assert addr_ok for that cycle, clear bc, and go to REFILL.
- REFILL: rready=1. Each rvalid beat writes lb[bc] and increments bc; bc wraps modulo W. The beat with rlast writes the full line (including that beat) to the victim way, sets valid, writes the tag, and goes to RESP.
- RESP: data_ok=1, with rdata taken from lb at the latched offset. Go to IDLE.
- rvalid mask: bit k = (offset_word + k < W); masked words drive 0.
- flush outside IDLE: set flush_pending. It is applied on the IDLE entry cycle after RESP, which also invalidates the just-filled line. The RESP data is still returned.
- Reset: all valid bits and vp cleared, state IDLE. An outstanding AXI transaction is abandoned and its later beats are ignored (rready=0).
- Reset values of outputs: addr_ok=0, data_ok=0, rdata=0, rvalid=0, arvalid=0, rready=0, araddr=0.

## Timing
- Hit: 0-cycle; addr_ok and data_ok are asserted in the request cycle.
- Miss: request in cycle C, then arvalid from C+1 until the handshake. With beat rlast at cycle R, data_ok is at R+1 and the FSM is in IDLE at R+2, accepting the next request.
- arvalid stays stable until arready; araddr is constant during MISS/REFILL.
- rvalid with rready=0 (IDLE/MISS/RESP) is never consumed.
- Hits are not served during MISS, REFILL or RESP; the block is blocking.

## Test plan
- Cold miss: rst, req addr 0x1FC0_0004, 8-beat refill 0xA0..0xA7 with arready after 2 cycles. Required: araddr=0x1FC0_0000, arlen=7, data_ok at rlast+1, rdata={0xA2,0xA1}, rvalid=2'b11.
- Re-fetch 0x1FC0_001C: hit in the same cycle, rdata word0=0xA7, rvalid=2'b01, word1=0.
- Conflict: with WAY_NUM=2, miss on three tags mapping to index 0. The third refill replaces way 0 and vp[0] becomes 1; a fourth tag replaces way 1.
- Flush in IDLE, then re-fetch 0x1FC0_0004: no data_ok in the flush cycle, then a miss with a new AR request.
- Flush pulse mid-REFILL: RESP still returns the correct data; the next fetch of the same line misses.
- rst asserted during REFILL after 3 beats: arvalid=rready=0 next cycle, remaining beats are ignored, and a fetch to the same line misses.
